// File: rtl/packer_config_sequencer.sv
// ---------------------------------------------------------------------------
// packer_config_sequencer
//
// Purpose:
//   Holds shadow copies of the per-chain condition and firmware tables of one
//   data packer. It loads them into the packer over the byte-stream config port
//   (configId/configData) when the host asks for it.
//   A reconfiguration pass has four steps:
//     1. Wait for the trace pipeline to drain.
//     2. Drop tracing.
//     3. Stream 2*MAX_CHAINS bytes: all condition bytes first, then all
//        firmware bytes.
//     4. Park configId on IDLE_CONFIG_ID for one cycle. This resets the
//        downstream byte counter. Tracing is then restored.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cfg_wr_en       shadow-table write strobe (accepted only when idle)
//   cfg_wr_sel      0: condition table, 1: firmware table
//   cfg_wr_chain    chain index written
//   cfg_wr_data     byte written
//   cfg_wr_err      1-cycle pulse: the previous write was dropped
//   start           request a reconfiguration pass (coalesced while busy)
//   target_id       config id of the block to program, sampled on pass entry
//   trace_en        host tracing enable
//   upstream_valid  valid of data in flight toward the packer
//   tracing         tracing enable driven to the packer
//   configId        config bus id (IDLE_CONFIG_ID when not streaming)
//   configData      config bus byte
//   busy            high whenever a pass is in progress
//   done            1-cycle pulse when a pass completes
// ---------------------------------------------------------------------------
module packer_config_sequencer #(
  parameter int         MAX_CHAINS     = 4,
  parameter int         DRAIN_CYCLES   = 2,
  parameter logic [7:0] IDLE_CONFIG_ID = 8'hFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_wr_en,
  input  logic                          cfg_wr_sel,
  input  logic [$clog2(MAX_CHAINS)-1:0] cfg_wr_chain,
  input  logic [7:0]                    cfg_wr_data,
  output logic                          cfg_wr_err,
  input  logic                          start,
  input  logic [7:0]                    target_id,
  input  logic                          trace_en,
  input  logic                          upstream_valid,
  output logic                          tracing,
  output logic [7:0]                    configId,
  output logic [7:0]                    configData,
  output logic                          busy,
  output logic                          done
);

  localparam int CW     = $clog2(MAX_CHAINS);
  localparam int NBYTES = 2 * MAX_CHAINS;
  localparam int KW     = $clog2(NBYTES);
  localparam int QW     = $clog2(DRAIN_CYCLES + 1);

  localparam logic [KW-1:0] IDX_LAST   = KW'(NBYTES - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

  // State
  logic [1:0]    state_q, state_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic [KW-1:0] idx_q, idx_d;
  logic          pending_q, pending_d;
  logic [7:0]    tgt_q, tgt_d;

  // Shadow tables
  logic [7:0] cond_q [MAX_CHAINS];
  logic [7:0] fw_q   [MAX_CHAINS];

  // Next output values, registered below
  logic       tracing_d, busy_d, done_d, wr_err_d;
  logic [7:0] config_id_d, config_data_d;
  logic       wr_ok;

  // Stream byte k: condition bytes occupy k < MAX_CHAINS, firmware bytes follow.
  function automatic logic [7:0] byte_at(input logic [KW-1:0] k);
    if (int'(k) < MAX_CHAINS) return cond_q[CW'(k)];
    else                      return fw_q[CW'(k - KW'(MAX_CHAINS))];
  endfunction

  // Writes only land while idle, so the tables are stable for a whole pass.
  assign wr_ok = cfg_wr_en && (state_q == ST_IDLE) && (int'(cfg_wr_chain) < MAX_CHAINS);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    quiet_d   = quiet_q;
    idx_d     = idx_q;
    tgt_d     = tgt_q;
    pending_d = pending_q | (start && (state_q != ST_IDLE));
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRAIN;
          quiet_d = '0;
          tgt_d   = target_id;
        end
      end
      ST_DRAIN: begin
        // Any in-flight beat restarts the quiet window; there is no timeout.
        if (upstream_valid) begin
          quiet_d = '0;
        end else if (quiet_q == QUIET_LAST) begin
          state_d = ST_STREAM;
          idx_d   = '0;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      ST_STREAM: begin
        if (idx_q == IDX_LAST) state_d = ST_FLUSH;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_FLUSH: begin
        done_d = 1'b1;
        // A start seen in this very cycle also counts toward the rerun.
        if (pending_q || start) begin
          state_d   = ST_DRAIN;
          quiet_d   = '0;
          tgt_d     = target_id;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are a function of the state being entered. tracing therefore
    // drops on the same edge where configId switches to the target.
    tracing_d     = ((state_d == ST_IDLE) || (state_d == ST_DRAIN)) ? trace_en : 1'b0;
    config_id_d   = (state_d == ST_STREAM) ? tgt_d : IDLE_CONFIG_ID;
    config_data_d = (state_d == ST_STREAM) ? byte_at(idx_d) : 8'h00;
    busy_d        = (state_d != ST_IDLE);
    wr_err_d      = cfg_wr_en && !wr_ok;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      quiet_q    <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      tgt_q      <= '0;
      tracing    <= 1'b0;
      configId   <= IDLE_CONFIG_ID;
      configData <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_wr_err <= 1'b0;
      // NOTE: the shadow tables are reset on purpose. All-zero means
      // "unconditional, length N", a safe firmware image after reset. These
      // are a handful of flops, not a RAM macro.
      for (int i = 0; i < MAX_CHAINS; i++) begin
        cond_q[i] <= 8'h00;
        fw_q[i]   <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      quiet_q    <= quiet_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      tgt_q      <= tgt_d;
      tracing    <= tracing_d;
      configId   <= config_id_d;
      configData <= config_data_d;
      busy       <= busy_d;
      done       <= done_d;
      cfg_wr_err <= wr_err_d;
      if (wr_ok) begin
        if (cfg_wr_sel) fw_q[cfg_wr_chain]   <= cfg_wr_data;
        else            cond_q[cfg_wr_chain] <= cfg_wr_data;
      end
    end
  end

endmodule
